// File: rtl/y86_mem_loader.sv
// y86_mem_loader: framed byte-stream loader that writes CPU memory and holds the CPU in reset until an end frame; define Y86_LOADER_CHECKSUM_EN for per-frame XOR checksums
module y86_mem_loader #(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              err
);
    typedef enum logic [3:0] {IDLE, ADDR0, ADDR1, LEN0, LEN1, DATA, CSUM, DONE, ERR} state_t;
    state_t state, state_n;
    logic [ADDR_W-1:0] addr;
    logic [15:0] len, len_in;
    logic [7:0] lo;
    logic acc;
`ifdef Y86_LOADER_CHECKSUM_EN
    localparam state_t END_NEXT = CSUM;
    localparam state_t DATA_NEXT = CSUM;
    logic [7:0] csum;
    logic is_end;
`else
    localparam state_t END_NEXT = DONE;
    localparam state_t DATA_NEXT = IDLE;
`endif
    assign len_in = {in_data, lo};
    assign in_ready = state != DONE && state != ERR;
    assign acc = in_valid && in_ready;
    assign cpu_hold = state != DONE;
    assign done = state == DONE;
    assign err = state == ERR;
    // frame parser next-state decode, advancing only on accepted bytes
    always_comb begin
        state_n = state;
        if (acc) begin
            case (state)
                IDLE:  state_n = in_data == 8'h86 ? ADDR0 : ERR;
                ADDR0: state_n = ADDR1;
                ADDR1: state_n = LEN0;
                LEN0:  state_n = LEN1;
                LEN1:  state_n = len_in != 16'd0 ? DATA : END_NEXT;
                DATA:  state_n = len == 16'd1 ? DATA_NEXT : DATA;
`ifdef Y86_LOADER_CHECKSUM_EN
                CSUM:  state_n = in_data != csum ? ERR : is_end ? DONE : IDLE;
`endif
                default: state_n = state;
            endcase
        end
    end
    // state, header capture and one-cycle registered write per data byte
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            mem_we <= 1'b0;
            mem_addr <= '0;
            mem_wdata <= 8'd0;
            addr <= '0;
            len <= 16'd0;
            lo <= 8'd0;
        end else begin
            state <= state_n;
            mem_we <= acc && state == DATA;
            if (acc) begin
                case (state)
                    ADDR0, LEN0: lo <= in_data;
                    ADDR1: addr <= ADDR_W'({in_data, lo});
                    LEN1: len <= len_in;
                    DATA: begin
                        mem_addr <= addr;
                        mem_wdata <= in_data;
                        addr <= addr + ADDR_W'(1);
                        len <= len - 16'd1;
                    end
                    default: ;
                endcase
            end
        end
    end
`ifdef Y86_LOADER_CHECKSUM_EN
    // running XOR of the bytes after the magic byte, and whether this frame is the end frame
    always_ff @(posedge clk) begin
        if (rst) begin
            csum <= 8'd0;
            is_end <= 1'b0;
        end else if (acc) begin
            if (state == IDLE) csum <= 8'd0;
            else if (state != CSUM) csum <= csum ^ in_data;
            if (state == LEN1) is_end <= len_in == 16'd0;
        end
    end
`endif
endmodule

// File: tb/tb_y86_mem_loader.sv
// tb_y86_mem_loader: randomized frame stimulus checked against a byte-level loader model
module tb_y86_mem_loader;
    logic clk = 0, rst = 1, in_valid = 0;
    logic [7:0] in_data = 0;
    logic in_ready, mem_we, cpu_hold, done, err;
    logic [15:0] mem_addr;
    logic [7:0] mem_wdata;
    int total = 0, bad = 0, wr_cnt = 0, exp_wr = 0;
    bit gaps = 0;
    logic [7:0] ref_mem [int];
    logic [7:0] dut_mem [int];
    logic [7:0] q [$];
    logic [7:0] cs;

    y86_mem_loader #(.ADDR_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_hold(cpu_hold), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (mem_we) begin
        dut_mem[int'(mem_addr)] = mem_wdata;
        wr_cnt++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1;
        in_valid = 0;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        chk("rst_we", mem_we, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_hold", cpu_hold, 1);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_ready", in_ready, 1);
    endtask

    task automatic put(input logic [7:0] b, input bit wr, input logic [15:0] a);
        if (gaps) repeat ($urandom_range(0, 2)) begin
            in_valid = 0;
            in_data = 8'($urandom);
            @(posedge clk);
            #1 chk("gap_we", mem_we, 0);
        end
        chk("ready", in_ready, 1);
        in_valid = 1;
        in_data = b;
        @(posedge clk);
        #1 in_valid = 0;
        chk("we", mem_we, wr);
        if (wr) begin
            chk("addr", mem_addr, a);
            chk("wdata", mem_wdata, b);
        end
    endtask

    task automatic send_hdr(input logic [15:0] a, input logic [15:0] n);
        put(8'h86, 0, 0);
        cs = a[7:0] ^ a[15:8] ^ n[7:0] ^ n[15:8];
        put(a[7:0], 0, 0);
        put(a[15:8], 0, 0);
        put(n[7:0], 0, 0);
        put(n[15:8], 0, 0);
    endtask

    task automatic send_data(input logic [15:0] a);
        foreach (q[i]) begin
            logic [15:0] ad = a + 16'(i);
            put(q[i], 1, ad);
            ref_mem[int'(ad)] = q[i];
            exp_wr++;
            cs ^= q[i];
        end
    endtask

    task automatic send_frame(input logic [15:0] a);
        send_hdr(a, 16'(q.size()));
        send_data(a);
`ifdef Y86_LOADER_CHECKSUM_EN
        put(cs, 0, 0);
`endif
        chk("frame_idle_ready", in_ready, 1);
        chk("frame_hold", cpu_hold, 1);
    endtask

    task automatic end_frame();
        send_hdr(16'h0000, 16'h0000);
`ifdef Y86_LOADER_CHECKSUM_EN
        put(cs, 0, 0);
`endif
        chk("end_done", done, 1);
        chk("end_hold", cpu_hold, 0);
        chk("end_ready", in_ready, 0);
        chk("end_err", err, 0);
    endtask

    initial begin
        do_reset();
        q.delete();
        q.push_back(8'h30);
        q.push_back(8'hF2);
        q.push_back(8'h0A);
        send_frame(16'h0100);
        end_frame();
        do_reset();
`ifdef Y86_LOADER_CHECKSUM_EN
        q.delete();
        q.push_back(8'hAB);
        send_hdr(16'h0010, 16'd1);
        send_data(16'h0010);
        chk("csum_val", cs, 8'hBA);
        put(8'hBA, 0, 0);
        chk("csum_ok_ready", in_ready, 1);
        chk("csum_ok_err", err, 0);
        send_hdr(16'h0010, 16'd1);
        send_data(16'h0010);
        put(8'hBB, 0, 0);
        chk("csum_bad_err", err, 1);
        chk("csum_bad_ready", in_ready, 0);
        chk("csum_bad_hold", cpu_hold, 1);
        do_reset();
`endif
        put(8'h55, 0, 0);
        chk("magic_err", err, 1);
        chk("magic_ready", in_ready, 0);
        chk("magic_done", done, 0);
        chk("magic_hold", cpu_hold, 1);
        repeat (3) begin
            in_valid = 1;
            in_data = 8'h86;
            @(posedge clk);
            #1 chk("magic_we", mem_we, 0);
            chk("magic_sticky", err, 1);
        end
        in_valid = 0;
        do_reset();
        gaps = 1;
        q.delete();
        q.push_back(8'h11);
        q.push_back(8'h22);
        q.push_back(8'h33);
        send_frame(16'hFFFE);
        for (int k = 0; k < 8; k++) begin
            logic [15:0] base = k < 2 ? 16'hFFFC + 16'(k) : 16'($urandom_range(16'h0100, 16'h010F));
            q.delete();
            repeat ($urandom_range(1, 8)) q.push_back(8'($urandom));
            send_frame(base);
        end
        q.delete();
        q.push_back(8'hC1);
        q.push_back(8'hC2);
        send_hdr(16'h0200, 16'd5);
        send_data(16'h0200);
        in_valid = 1;
        in_data = 8'hC3;
        rst = 1;
        @(posedge clk);
        #1 rst = 0;
        in_valid = 0;
        chk("midrst_we", mem_we, 0);
        chk("midrst_ready", in_ready, 1);
        chk("midrst_hold", cpu_hold, 1);
        chk("midrst_done", done, 0);
        q.delete();
        repeat (4) q.push_back(8'($urandom));
        send_frame(16'h0201);
        end_frame();
        repeat (3) begin
            in_valid = 1;
            in_data = 8'h86;
            @(posedge clk);
            #1 chk("done_sticky", done, 1);
            chk("done_we", mem_we, 0);
        end
        in_valid = 0;
        @(posedge clk);
        #1;
        foreach (ref_mem[k]) chk($sformatf("mem_%0h", k), dut_mem.exists(k) ? dut_mem[k] : 8'hxx, ref_mem[k]);
        chk("wr_count", wr_cnt, exp_wr);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/y86_mem_loader.md
# y86_mem_loader

Byte-stream program loader for the Y86 pipelined CPU: receives framed bytes over a valid/ready handshake and writes them into CPU memory through a byte write port. It holds the CPU in reset until an end-of-load frame is accepted, then releases it. It is the write-side counterpart of the simulation-time register/memory monitor, and lets benches and FPGA builds load programs without `$readmemh`.

## Interface

Parameters:
- `ADDR_W`, default 16: memory byte-address width.

Ports (clock and reset first; reset is synchronous and active-high):
- `clk` input 1: clock; all state changes on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: `in_data` is valid.
- `in_data` input 8: stream byte.
- `in_ready` output 1: loader can accept a byte.
- `mem_we` output 1: memory byte write strobe.
- `mem_addr` output ADDR_W: write byte address.
- `mem_wdata` output 8: write byte.
- `cpu_hold` output 1: drives the CPU reset.
  - 1 = CPU held in reset.
- `done` output 1: end frame accepted; sticky.
- `err` output 1: protocol or checksum error; sticky.

## Operation

- A byte is accepted on a rising edge where `in_valid && in_ready`.
- Frame format:
  - Magic byte `0x86`.
  - `addr_lo`, `addr_hi`: little-endian start address, truncated or zero-extended to ADDR_W.
  - `len_lo`, `len_hi`: little-endian byte count, 0 to 65535.
  - `len` data bytes.
  - One checksum byte, present only when the checksum macro is defined (see Configuration).
- FSM states: IDLE, ADDR0, ADDR1, LEN0, LEN1, DATA, CSUM, DONE, ERR.
  - IDLE: byte `0x86` → ADDR0; any other byte → ERR.
  - ADDR0 → ADDR1 → LEN0 → LEN1, one accepted byte each.
  - LEN1, with `len` != 0: → DATA.
  - LEN1, with `len` == 0 (end frame): → CSUM if checksum is enabled, else → DONE.
  - DATA: each accepted byte issues one write at the current address, then the address increments and the remaining count decrements. After the last byte → CSUM (checksum enabled) or IDLE (disabled).
  - CSUM: byte equal to the running checksum → IDLE for a data frame, or DONE for the end frame. Mismatch → ERR.
  - DONE and ERR are terminal until `rst`.
- `in_ready` is a combinational decode of the state: 1 in every state except DONE and ERR.
- Address arithmetic is modulo 2^ADDR_W. For example, with ADDR_W=16, a write at 0xFFFF is followed by a write at 0x0000. No error is raised on wrap.
- Multiple data frames may precede the end frame. Later writes to the same address overwrite earlier ones.
- `cpu_hold` is 1 in every state except DONE. In ERR the CPU stays held.

## Timing

- Reset values: `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `cpu_hold`=1, `done`=0, `err`=0, state IDLE, so `in_ready`=1 from the first cycle after reset.
- Write latency is 1 cycle:
  - A data byte accepted at edge N produces `mem_we`=1, `mem_addr`, `mem_wdata` registered at edge N, visible during cycle N→N+1.
  - `mem_we` is a single-cycle pulse per byte.
- Back-to-back acceptance: one byte per cycle, with no bubbles in any state.
- `done` rises and `cpu_hold` falls at the same edge that accepts the final byte of the end frame: `len_hi` if checksum is disabled, the checksum byte if enabled.
- `err` rises at the edge that accepts the offending byte. `in_ready` is 0 from the following cycle.
- Bytes presented while `in_valid`=0 are ignored; the FSM holds.
- `rst` asserted mid-frame:
  - All state returns to IDLE next edge and `cpu_hold` returns to 1.
  - A write registered that cycle is squashed: `mem_we`=0 after the reset edge.
  - Memory contents already written are not cleared.
- `rst` takes priority over a simultaneous byte acceptance.

## Configuration

- Macro `Y86_LOADER_CHECKSUM_EN`.
  - Defined:
    - Every frame, including the end frame, carries a trailing checksum byte.
    - The checksum is the XOR of all frame bytes after the magic byte (addr_lo through the last data byte), reset to 0 at each magic byte.
    - Mismatch → ERR.
  - Undefined:
    - No checksum byte and no CSUM state.
    - DATA → IDLE after the last byte; LEN1 with `len`=0 → DONE.
    - `err` is set only by a bad magic byte.

## Test plan

- Single frame, checksum disabled:
  - Stimulus: `86 00 01 03 00 30 F2 0A`, then end frame `86 00 00 00 00`.
  - Response: writes `0x0100`=0x30, `0x0101`=0xF2, `0x0102`=0x0A on three consecutive cycles.
  - Then `done`=1 and `cpu_hold`=0; the CPU fetches from address 0 and the bench sees the expected register results.
- Checksum enabled, good and bad:
  - Stimulus: frame `86 10 00 01 00 AB`, checksum `0xBA`.
  - Response: write `0x0010`=0xAB, then IDLE.
  - Repeat with checksum `0xBB`: `err`=1 and `in_ready`=0 next cycle; `cpu_hold` stays 1.
- Bad magic:
  - Stimulus: first byte `0x55`.
  - Response: `err`=1, no `mem_we` ever, `done`=0.
- Address wrap:
  - Stimulus: ADDR_W=16, frame at addr `0xFFFE`, len 3.
  - Response: writes at `0xFFFE`, `0xFFFF`, `0x0000`.
- Handshake gaps and mid-frame reset:
  - Stimulus: toggle `in_valid` randomly.
  - Response: write count equals `len` and there are no duplicate writes.
  - Stimulus: assert `rst` after the 2nd data byte.
  - Response: state IDLE, `mem_we`=0, `cpu_hold`=1. A fresh frame then loads correctly.
